// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD-to-binary converter: state encoding,
// digit limits, adjust constant and the blank seven-segment pattern.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] ADJ       = 4'd3;
    localparam int         N_STEPS   = 7;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Reverse double-dabble correction: a nibble that picked up the shifted-in
    // weight of 8 really carried a decimal 5, so pull it back by 3.
    function automatic logic [3:0] adjust_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? (n - ADJ) : n;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to active-low seven-segment pattern, segment a at index 0.
// Anything above 9 is shown blank.
module seg7_digit (
    input  logic [3:0] value,
    output logic [0:6] seg
);
    import bcd_pkg::*;

    always_comb begin
        seg = SEG_BLANK;
        unique case (value)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Two-digit BCD to binary converter using a shift-right / subtract-3 loop,
// one bit per clock, with seven-segment echo of the captured digits.
module bcd_to_bin_seq #(
    parameter int N_STEPS = bcd_pkg::N_STEPS
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] D1,
    input  logic [3:0] D0,
    output logic [6:0] Bin,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0
);
    import bcd_pkg::*;

    localparam int              CNT_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEPS - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       bcd;
    logic [6:0]       work;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shown;
    logic             shown_vld;
    logic [6:0]       result;
    logic             err;

    logic             digits_ok;
    logic [14:0]      shifted;
    logic [7:0]       bcd_step;
    logic [6:0]       work_step;
    logic [3:0]       hex1_val;
    logic [3:0]       hex0_val;

    assign digits_ok = (D1 <= BCD_MAX) && (D0 <= BCD_MAX);

    assign shifted   = {bcd, work} >> 1;
    assign bcd_step  = {adjust_nibble(shifted[14:11]), adjust_nibble(shifted[10:7])};
    assign work_step = shifted[6:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = digits_ok ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers only move in IDLE (capture) and SHIFT (iterate);
    // result/err are the held outputs and change only on capture or completion.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bcd       <= '0;
            work      <= '0;
            cnt       <= '0;
            shown     <= '0;
            shown_vld <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        shown     <= {D1, D0};
                        shown_vld <= 1'b1;
                        if (digits_ok) begin
                            bcd  <= {D1, D0};
                            work <= '0;
                            cnt  <= '0;
                            err  <= 1'b0;
                        end else begin
                            err    <= 1'b1;
                            result <= '0;
                        end
                    end
                end
                SHIFT: begin
                    bcd  <= bcd_step;
                    work <= work_step;
                    if (cnt == LAST) begin
                        result <= work_step;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Bin = result;
    assign Err = err;

    // Nothing captured yet (or just reset) is driven as an out-of-range digit to blank the display.
    assign hex1_val = shown_vld ? shown[7:4] : 4'hF;
    assign hex0_val = shown_vld ? shown[3:0] : 4'hF;

    seg7_digit u_hex1 (
        .value(hex1_val),
        .seg  (HEX1)
    );

    seg7_digit u_hex0 (
        .value(hex0_val),
        .seg  (HEX0)
    );

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus queues expected results with
// their completion cycle, a monitor pops and compares on every Done pulse.
module tb_bcd_to_bin_seq;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] D1;
    logic [3:0] D0;
    logic [6:0] Bin;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic [0:6] HEX1;
    logic [0:6] HEX0;

    localparam logic [0:6] SEG_0 = 7'b0000001;
    localparam logic [0:6] SEG_1 = 7'b1001111;
    localparam logic [0:6] SEG_2 = 7'b0010010;
    localparam logic [0:6] SEG_3 = 7'b0000110;
    localparam logic [0:6] SEG_4 = 7'b1001100;
    localparam logic [0:6] SEG_5 = 7'b0100100;
    localparam logic [0:6] SEG_7 = 7'b0001111;
    localparam logic [0:6] SEG_9 = 7'b0000100;
    localparam logic [0:6] BLANK = 7'b1111111;

    bcd_to_bin_seq #(.N_STEPS(7)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .D1   (D1),
        .D0   (D0),
        .Bin  (Bin),
        .Busy (Busy),
        .Done (Done),
        .Err  (Err),
        .HEX1 (HEX1),
        .HEX0 (HEX0)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] bin;
        logic       err;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                check("done_without_request", {31'd0, Done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("bin",        {25'd0, Bin}, {25'd0, mon_e.bin});
                check("err",        {31'd0, Err}, {31'd0, mon_e.err});
                check("done_cycle", cyc,          mon_e.at);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 14 && sb.size() != 0; i++) begin
            @(posedge Clock);
            #1;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge Clock);
        #1;
    endtask

    task automatic convert(input logic [3:0] d1, input logic [3:0] d0,
                           input logic [6:0] eb, input logic ee,
                           input logic [0:6] h1, input logic [0:6] h0);
        @(posedge Clock);
        #1;
        D1    = d1;
        D0    = d0;
        Start = 1'b1;
        sb.push_back('{eb, ee, cyc + (ee ? 1 : 8)});
        @(posedge Clock);
        #1;
        Start = 1'b0;
        D1    = ~d1;
        D0    = ~d0;
        if (!ee) check("busy_after_capture", {31'd0, Busy}, 32'd1);
        wait_drain();
        check("hex1",     {25'd0, HEX1}, {25'd0, h1});
        check("hex0",     {25'd0, HEX0}, {25'd0, h0});
        check("bin_hold", {25'd0, Bin},  {25'd0, eb});
        check("err_hold", {31'd0, Err},  {31'd0, ee});
        check("idle_busy", {31'd0, Busy}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bin"},  {25'd0, Bin},  32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_done"}, {31'd0, Done}, 32'd0);
        check({tag, "_err"},  {31'd0, Err},  32'd0);
        check({tag, "_hex1"}, {25'd0, HEX1}, {25'd0, BLANK});
        check({tag, "_hex0"}, {25'd0, HEX0}, {25'd0, BLANK});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        Reset = 1'b1;
        Start = 1'b1;
        D1    = 4'd4;
        D0    = 4'd2;
        repeat (3) @(posedge Clock);
        #1;
        check_reset_state("reset");
        Reset = 1'b0;
        Start = 1'b0;

        convert(4'd4, 4'd2, 7'h2A, 1'b0, SEG_4, SEG_2);
        convert(4'd9, 4'd9, 7'h63, 1'b0, SEG_9, SEG_9);
        convert(4'd0, 4'd0, 7'h00, 1'b0, SEG_0, SEG_0);
        convert(4'hA, 4'd3, 7'h00, 1'b1, BLANK, SEG_3);
        convert(4'd1, 4'd0, 7'h0A, 1'b0, SEG_1, SEG_0);

        // Re-pulses during SHIFT and during DONE must be dropped.
        @(posedge Clock);
        #1;
        D1 = 4'd2; D0 = 4'd5; Start = 1'b1;
        c = cyc;
        sb.push_back('{7'h19, 1'b0, c + 8});
        @(posedge Clock);
        #1;
        Start = 1'b0;
        while (cyc < c + 3) begin @(posedge Clock); #1; end
        D1 = 4'd8; D0 = 4'd8; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        while (cyc < c + 8) begin @(posedge Clock); #1; end
        D1 = 4'd6; D0 = 4'd6; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (12) @(posedge Clock);
        #1;
        wait_drain();
        check("repulse_bin",  {25'd0, Bin},  32'h19);
        check("repulse_hex1", {25'd0, HEX1}, {25'd0, SEG_2});
        check("repulse_hex0", {25'd0, HEX0}, {25'd0, SEG_5});

        // Reset part-way through SHIFT: no Done, everything cleared.
        @(posedge Clock);
        #1;
        D1 = 4'd1; D0 = 4'd7; Start = 1'b1;
        c = cyc;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        while (cyc < c + 3) begin @(posedge Clock); #1; end
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check_reset_state("abort");
        repeat (10) @(posedge Clock);
        #1;
        convert(4'd3, 4'd1, 7'h1F, 1'b0, SEG_3, SEG_1);

        // Start held high: a new conversion every 9 cycles.
        @(posedge Clock);
        #1;
        D1 = 4'd5; D0 = 4'd7; Start = 1'b1;
        c = cyc;
        sb.push_back('{7'h39, 1'b0, c + 8});
        sb.push_back('{7'h39, 1'b0, c + 17});
        sb.push_back('{7'h39, 1'b0, c + 26});
        while (cyc < c + 27) begin @(posedge Clock); #1; end
        Start = 1'b0;
        wait_drain();
        check("held_bin",  {25'd0, Bin},  32'h39);
        check("held_hex1", {25'd0, HEX1}, {25'd0, SEG_5});
        check("held_hex0", {25'd0, HEX0}, {25'd0, SEG_7});

        repeat (4) @(posedge Clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 SHALL have parameter N_STEPS, default 7, number of shift/adjust iterations (binary result width).
REQ-002 SHALL have port Clock, input, 1, the single rising-edge clock.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start, input, 1, request to convert, sampled only in IDLE.
REQ-005 SHALL have port D1, input, 4, BCD tens digit.
REQ-006 SHALL have port D0, input, 4, BCD ones digit.
REQ-007 SHALL have port Bin, output, 7, binary result 0..99.
REQ-008 SHALL have port Busy, output, 1, high while converting.
REQ-009 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port Err, output, 1, high when the last request had a digit >9.
REQ-011 SHALL have ports HEX1 and HEX0, output, 7 each, bit order [0:6], active-low segments showing the captured D1 and D0.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE with Start=1 and both digits <=9 SHALL capture {D1,D0} into an 8-bit BCD register, clear the 7-bit binary register and step counter, and go to SHIFT.
REQ-014 IDLE with Start=1 and either digit >9 SHALL set Err=1, force Bin=0, skip SHIFT and go to DONE.
REQ-015 Each SHIFT cycle SHALL shift {bcd,bin} right by 1 (the BCD LSB enters the bin MSB), then subtract 3 from each BCD nibble that is >=8.
REQ-016 SHIFT SHALL last exactly N_STEPS cycles (counter 0..N_STEPS-1, no wrap past N_STEPS-1), then go to DONE.
REQ-017 DONE SHALL last one cycle with Done=1, then return to IDLE unconditionally.
REQ-018 Latency: Start sampled at edge k SHALL give Busy=1 after edges k+1..k+7, and Done=1 with valid Bin after edge k+8.
REQ-019 For an invalid digit, Done SHALL assert after edge k+1.
REQ-020 Bin and Err SHALL hold their values from DONE until the next accepted Start.
REQ-021 A valid Start SHALL clear Err.
REQ-022 Start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-023 Start held high SHALL launch a new conversion on every IDLE cycle.
REQ-024 D1/D0 changes after capture SHALL NOT affect an in-progress conversion.
REQ-025 HEX outputs SHALL show the captured digits, and SHALL be blank (all 1) for captured values >9.

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE, Bin=0, Busy=0, Done=0, Err=0, internal registers=0 and HEX1/HEX0 blank, overriding Start in the same cycle.
REQ-027 Reset mid-SHIFT SHALL abort the conversion without asserting Done.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the state encoding, BCD_MAX=9, ADJ=3, N_STEPS=7 and the blank segment constant.
REQ-029 A single sub-module seg7_digit (4-bit value to [0:6] active-low segments, blank above 9) SHALL be instantiated twice.

Verification
REQ-030 D1=4, D0=2, Start pulse -> Done at cycle 8, Bin=0x2A, Err=0, HEX1="4", HEX0="2".
REQ-031 D1=9, D0=9 -> Bin=0x63; D1=0, D0=0 -> Bin=0x00; both with Err=0.
REQ-032 D1=0xA, D0=3 -> Done one cycle after Start, Err=1, Bin=0, HEX1 blank.
REQ-033 Start re-pulsed at cycles 3 and 8 with new digits -> both ignored; first result unchanged, no extra Done.
REQ-034 Reset at cycle 4 of a conversion -> no Done; all outputs 0 or blank next cycle; a fresh Start then converts correctly.
REQ-035 Start held high with D1=5, D0=7 -> Done pulse every 9 cycles, Bin=0x39 each time.
